decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Decode/register-read stage directly upstream of execute. It takes the fetched instruction word and PC, splits the word into the op_type/instr/imm/branch/jump form that execute consumes, reads the dual GPR/FPR register file, and handles writeback into that file. It also detects load-use hazards and holds the DE pipeline register while execute is stalled (UART busy, multi-cycle ops) or during a branch redirect.

Parameters:
RA_REG, 31, GPR index written by JAL
LOAD_BUBBLES, 1, bubbles inserted after LW/LW_S on a dependent read (BRAM read latency)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
fd_valid  in  1  fetch word valid
fd_instr  in  32  instruction word
fd_pc  in  32  PC of fd_instr
fd_ready  out  1  decode accepts fd word this cycle
ex_stall  in  1  execute busy (uart_state or multi-cycle); hold DE register
flush  in  1  taken branch/jump redirect; kill DE and current fd word
wb_rw  in  2  writeback target: 00 none, 01 GPR, 10 FPR, 11 none
wb_rd  in  5  writeback register index
wb_d  in  32  writeback data
de_valid  out  1  DE register holds a real instruction (execute start)
de_pc  out  32  PC
de_op_type  out  2  00 I/J, 01 R (funct), 10 FPU (funct)
de_instr  out  6  opcode or funct, per constant package OP_*/FUNC_*/FPU_*
de_s, de_t  out  32  source operand values
de_rs, de_rt  out  6  source ids {bit5: 1=FPR, [4:0] index}, for execute forwarding
de_imm  out  32  extended immediate
de_branch, de_jump, de_is_jr  out  1  control-flow class
de_rw  out  2  destination file (encoding as wb_rw)
de_rd  out  5  destination index
hazard  out  1  bubble inserted this cycle

Behaviour:
- Reset (rstn=0 at posedge): every DE output, hazard, and all 64 registers = 0. fd_ready=0 during reset.
- Classification: opcode[31:26]=0 -> op_type 01, instr=funct; opcode=COP1 -> op_type 10, instr=funct; otherwise op_type 00, instr=opcode.
- Fields:
  - R-type: rs=[25:21], rt=[20:16], rd=[15:11]; imm=sext([15:0]), so shamt sits in imm[10:6].
  - FPU: fs=[15:11], ft=[20:16], fd=[10:6].
  - FPU_EQ/LT/LE/FTOI write GPR. ITOF reads GPR. All other FPU ops read and write FPR.
  - LW_S writes FPR. SW_S reads t from FPR.
- Immediate:
  - Sign-extend for ADDI, SLTI, LW, LW_S, SW, SW_S, branches.
  - Zero-extend for ANDI, ORI, XORI, LUI.
  - J/JAL: imm = zext([25:0]).
- Destination:
  - rw=00 for branches, J, JR, SW, SW_S, OUT, unknown opcodes.
  - JAL: rw=01, rd=RA_REG, de_s=fd_pc+4 (execute passes s through as the result).
  - JR: de_is_jr=1, de_jump=0.
- Register file:
  - GPR0 always reads 0; writes to GPR0 are dropped. FPR0 is an ordinary register.
  - Write-through: a read of a register being written by wb this cycle returns wb_d.
- Hazard:
  - DE holds LW/LW_S (de_valid) and the incoming word reads its destination (file and index both match; a GPR0 destination never matches) -> insert LOAD_BUBBLES cycles.
  - Bubble: de_valid=0, hazard=1, fd_ready=0, fd word held.
  - Forwarding of ALU results is execute's job.
- Priority at each posedge: reset > flush > ex_stall > hazard > advance.
  - Flush: de_valid<=0, fd word discarded, fd_ready=1, hazard=0. Flush wins over ex_stall.
  - ex_stall=1: all DE outputs hold unchanged, fd_ready=0, hazard=0. The hazard counter freezes.
  - Advance: fd_valid=1 loads the DE register and sets de_valid=1; fd_valid=0 loads de_valid=0 (bubble).
- Writeback proceeds regardless of stall/flush/hazard.
- Latency: one cycle from fd word accepted to DE outputs.

Test Plan:
- Reset with garbage on all inputs -> after one cycle de_valid=0, all DE outputs 0, read of any register = 0.
- Preload GPR2=10, decode 0x2043FFFB (ADDI $3,$2,-5) -> next cycle op_type=00, instr=OP_ADDI, de_s=10, imm=0xFFFFFFFB, rw=01, rd=3, rs=6'h02.
- wb_rw=01, wb_rd=5, wb_d=0x1234 in the same cycle as decode of ADD $6,$5,$0 -> de_s=0x1234, de_t=0; a write to GPR0 leaves reads at 0.
- LW $4,0($1) then ADD $7,$4,$4 -> one cycle with hazard=1, de_valid=0, fd_ready=0, then ADD issues. Same sequence with ADD $7,$5,$5 -> no bubble.
- JAL 0x40 at pc 0x100 -> de_jump=1, imm=0x40, de_s=0x104, rw=01, rd=31. ANDI with imm 0x8000 -> de_imm=0x00008000.
- ex_stall held 3 cycles -> DE outputs frozen, fd_ready=0; flush asserted during the stall -> next cycle de_valid=0, fd word dropped.

Source files
------------

// File: rtl/decode_stage_if.sv
// decode_stage_if.sv: opcode constants, the DE bundle type and the
// fetch->decode (fd_if) and decode->execute (de_if) port interfaces.

package decode_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BLEZ  = 6'h06;
   localparam logic [5:0] OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_COP1  = 6'h11;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_LW_S  = 6'h31;
   localparam logic [5:0] OP_SW_S  = 6'h39;
   localparam logic [5:0] OP_OUT   = 6'h3F;

   localparam logic [5:0] FUNC_JR  = 6'h08;

   localparam logic [5:0] FPU_SQRT = 6'h04;
   localparam logic [5:0] FPU_ABS  = 6'h05;
   localparam logic [5:0] FPU_MOV  = 6'h06;
   localparam logic [5:0] FPU_NEG  = 6'h07;
   localparam logic [5:0] FPU_ITOF = 6'h20;
   localparam logic [5:0] FPU_FTOI = 6'h24;
   localparam logic [5:0] FPU_EQ   = 6'h32;
   localparam logic [5:0] FPU_LT   = 6'h3C;
   localparam logic [5:0] FPU_LE   = 6'h3E;

   localparam logic [1:0] RW_NONE  = 2'b00;
   localparam logic [1:0] RW_GPR   = 2'b01;
   localparam logic [1:0] RW_FPR   = 2'b10;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [1:0]  op_type;
      logic [5:0]  instr;
      logic [31:0] s;
      logic [31:0] t;
      logic [5:0]  rs;
      logic [5:0]  rt;
      logic [31:0] imm;
      logic        branch;
      logic        jump;
      logic        is_jr;
      logic [1:0]  rw;
      logic [4:0]  rd;
   } id_ex_t;
endpackage

interface fd_if;
   logic        fd_valid;
   logic [31:0] fd_instr;
   logic [31:0] fd_pc;
   logic        fd_ready;

   modport master (output fd_valid, fd_instr, fd_pc,
                   input  fd_ready);
   modport slave  (input  fd_valid, fd_instr, fd_pc,
                   output fd_ready);
endinterface

interface de_if;
   logic        de_valid;
   logic [31:0] de_pc;
   logic [1:0]  de_op_type;
   logic [5:0]  de_instr;
   logic [31:0] de_s;
   logic [31:0] de_t;
   logic [5:0]  de_rs;
   logic [5:0]  de_rt;
   logic [31:0] de_imm;
   logic        de_branch;
   logic        de_jump;
   logic        de_is_jr;
   logic [1:0]  de_rw;
   logic [4:0]  de_rd;

   modport master (output de_valid, de_pc, de_op_type, de_instr,
                   output de_s, de_t, de_rs, de_rt, de_imm,
                   output de_branch, de_jump, de_is_jr,
                   output de_rw, de_rd);
   modport slave  (input  de_valid, de_pc, de_op_type, de_instr,
                   input  de_s, de_t, de_rs, de_rt, de_imm,
                   input  de_branch, de_jump, de_is_jr,
                   input  de_rw, de_rd);
endinterface

// File: rtl/decode_stage.sv
// decode_stage: splits the fetched word into execute's form, reads the
// GPR/FPR file (with write-through), inserts load-use bubbles and holds
// the DE register on ex_stall or kills it on flush.
// Ports: clk, rstn (sync, active low); fd (fd_if.slave: fd_valid,
// fd_instr, fd_pc, fd_ready); ex_stall, flush; wb_rw/wb_rd/wb_d
// writeback; de (de_if.master: DE register); hazard (bubble this cycle).

module decode_stage
   import decode_pkg::*;
#(
   parameter int RA_REG       = 31,
   parameter int LOAD_BUBBLES = 1
) (
   input  logic        clk,
   input  logic        rstn,
   fd_if.slave         fd,
   input  logic        ex_stall,
   input  logic        flush,
   input  logic [1:0]  wb_rw,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_d,
   de_if.master        de,
   output logic        hazard
);

   localparam int CW = $clog2(LOAD_BUBBLES + 1);

   logic [31:0]   gpr_q [32];
   logic [31:0]   fpr_q [32];
   id_ex_t        de_q, de_d, dec;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [31:0] w;
   logic [5:0]  op, fn;
   logic [4:0]  f_rs, f_rt, f_rd, f_fd;
   logic [31:0] imm_s, imm_z, imm_j;
   logic        link;

   assign w     = fd.fd_instr;
   assign op    = w[31:26];
   assign fn    = w[5:0];
   assign f_rs  = w[25:21];
   assign f_rt  = w[20:16];
   assign f_rd  = w[15:11];
   assign f_fd  = w[10:6];
   assign imm_s = {{16{w[15]}}, w[15:0]};
   assign imm_z = {16'h0000, w[15:0]};
   assign imm_j = {6'h00, w[25:0]};

   // Source ids are {file, index}; an unused source reads id 0
   // (GPR0), which is always 0 and never matches a load target.
   function automatic logic [31:0] rf_pick(
      input logic [5:0]  id,
      input logic [31:0] g,
      input logic [31:0] f,
      input logic [1:0]  rw,
      input logic [4:0]  rd,
      input logic [31:0] d
   );
      logic [31:0] r;
      logic        hit;
      hit = (rd == id[4:0]) &&
            (id[5] ? (rw == RW_FPR) : (rw == RW_GPR));
      if (id == 6'h00)
         r = 32'h0;
      else if (hit)
         r = d;
      else
         r = id[5] ? f : g;
      return r;
   endfunction

   always_comb begin
      dec         = '0;
      link        = 1'b0;
      dec.valid   = fd.fd_valid;
      dec.pc      = fd.fd_pc;
      dec.instr   = op;
      unique case (1'b1)
         (op == OP_RTYPE): begin
            dec.op_type = 2'b01;
            dec.instr   = fn;
            dec.rs      = {1'b0, f_rs};
            dec.rt      = {1'b0, f_rt};
            dec.imm     = imm_s;
            if (fn == FUNC_JR) begin
               dec.is_jr = 1'b1;
            end else begin
               dec.rw = RW_GPR;
               dec.rd = f_rd;
            end
         end
         (op == OP_COP1): begin
            dec.op_type = 2'b10;
            dec.instr   = fn;
            dec.rd      = f_fd;
            unique case (1'b1)
               (fn == FPU_EQ) || (fn == FPU_LT) ||
               (fn == FPU_LE): begin
                  dec.rs = {1'b1, f_rd};
                  dec.rt = {1'b1, f_rt};
                  dec.rw = RW_GPR;
               end
               (fn == FPU_FTOI): begin
                  dec.rs = {1'b1, f_rd};
                  dec.rw = RW_GPR;
               end
               (fn == FPU_ITOF): begin
                  dec.rs = {1'b0, f_rd};
                  dec.rw = RW_FPR;
               end
               (fn == FPU_SQRT) || (fn == FPU_ABS) ||
               (fn == FPU_MOV) || (fn == FPU_NEG): begin
                  dec.rs = {1'b1, f_rd};
                  dec.rw = RW_FPR;
               end
               default: begin
                  dec.rs = {1'b1, f_rd};
                  dec.rt = {1'b1, f_rt};
                  dec.rw = RW_FPR;
               end
            endcase
         end
         (op == OP_ADDI) || (op == OP_SLTI) ||
         (op == OP_LW): begin
            dec.rs  = {1'b0, f_rs};
            dec.imm = imm_s;
            dec.rw  = RW_GPR;
            dec.rd  = f_rt;
         end
         (op == OP_ANDI) || (op == OP_ORI) ||
         (op == OP_XORI) || (op == OP_LUI): begin
            dec.rs  = {1'b0, f_rs};
            dec.imm = imm_z;
            dec.rw  = RW_GPR;
            dec.rd  = f_rt;
         end
         (op == OP_LW_S): begin
            dec.rs  = {1'b0, f_rs};
            dec.imm = imm_s;
            dec.rw  = RW_FPR;
            dec.rd  = f_rt;
         end
         (op == OP_SW): begin
            dec.rs  = {1'b0, f_rs};
            dec.rt  = {1'b0, f_rt};
            dec.imm = imm_s;
         end
         (op == OP_SW_S): begin
            dec.rs  = {1'b0, f_rs};
            dec.rt  = {1'b1, f_rt};
            dec.imm = imm_s;
         end
         (op == OP_BEQ) || (op == OP_BNE) ||
         (op == OP_BLEZ) || (op == OP_BGTZ): begin
            dec.rs     = {1'b0, f_rs};
            dec.rt     = {1'b0, f_rt};
            dec.imm    = imm_s;
            dec.branch = 1'b1;
         end
         (op == OP_J): begin
            dec.imm  = imm_j;
            dec.jump = 1'b1;
         end
         (op == OP_JAL): begin
            dec.imm  = imm_j;
            dec.jump = 1'b1;
            dec.rw   = RW_GPR;
            dec.rd   = 5'(RA_REG);
            link     = 1'b1;
         end
         (op == OP_OUT): begin
            dec.rs = {1'b0, f_rs};
         end
         default: ;
      endcase
      // JAL's return address rides in s; execute passes it through.
      dec.s = link ? fd.fd_pc + 32'd4 :
              rf_pick(dec.rs, gpr_q[dec.rs[4:0]],
                      fpr_q[dec.rs[4:0]], wb_rw, wb_rd, wb_d);
      dec.t = rf_pick(dec.rt, gpr_q[dec.rt[4:0]],
                      fpr_q[dec.rt[4:0]], wb_rw, wb_rd, wb_d);
   end

   logic       ld_in_de, dep, bub_run, hold;
   logic [5:0] ld_dst;

   assign ld_in_de = de_q.valid && (de_q.op_type == 2'b00) &&
                     ((de_q.instr == OP_LW) ||
                      (de_q.instr == OP_LW_S));
   assign ld_dst   = {de_q.rw == RW_FPR, de_q.rd};
   assign dep      = ld_in_de && (ld_dst != 6'h00) &&
                     ((dec.rs == ld_dst) || (dec.rt == ld_dst));
   assign bub_run  = (cnt_q != '0);
   // cnt_q counts bubbles still owed after the first one.
   assign hold     = bub_run || (fd.fd_valid && dep);

   assign hazard      = rstn && !flush && !ex_stall && hold;
   assign fd.fd_ready = rstn &&
                        (flush || (!ex_stall && !hold));

   always_comb begin
      de_d  = de_q;
      cnt_d = cnt_q;
      if (flush) begin
         de_d.valid = 1'b0;
         cnt_d      = '0;
      end else if (ex_stall) begin
         de_d  = de_q;
      end else if (hold) begin
         de_d.valid = 1'b0;
         cnt_d      = bub_run ? cnt_q - CW'(1) :
                               CW'(LOAD_BUBBLES - 1);
      end else begin
         de_d = dec;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         de_q  <= '0;
         cnt_q <= '0;
      end else begin
         de_q  <= de_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < 32; i++) begin
            gpr_q[i] <= '0;
            fpr_q[i] <= '0;
         end
      end else begin
         if ((wb_rw == RW_GPR) && (wb_rd != 5'd0))
            gpr_q[wb_rd] <= wb_d;
         if (wb_rw == RW_FPR)
            fpr_q[wb_rd] <= wb_d;
      end
   end

   assign de.de_valid   = de_q.valid;
   assign de.de_pc      = de_q.pc;
   assign de.de_op_type = de_q.op_type;
   assign de.de_instr   = de_q.instr;
   assign de.de_s       = de_q.s;
   assign de.de_t       = de_q.t;
   assign de.de_rs      = de_q.rs;
   assign de.de_rt      = de_q.rt;
   assign de.de_imm     = de_q.imm;
   assign de.de_branch  = de_q.branch;
   assign de.de_jump    = de_q.jump;
   assign de.de_is_jr   = de_q.is_jr;
   assign de.de_rw      = de_q.rw;
   assign de.de_rd      = de_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed cases plus random traffic for decode_stage,
// checked against a behavioural decode/regfile/hazard model.

module tb_decode_stage;
   localparam int LB = 1;

   logic        clk = 1'b0;
   logic        rstn;
   logic        ex_stall;
   logic        flush;
   logic [1:0]  wb_rw;
   logic [4:0]  wb_rd;
   logic [31:0] wb_d;
   logic        hazard;

   fd_if fd_bus ();
   de_if de_bus ();

   decode_stage #(.RA_REG(31), .LOAD_BUBBLES(LB)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .fd       (fd_bus),
      .ex_stall (ex_stall),
      .flush    (flush),
      .wb_rw    (wb_rw),
      .wb_rd    (wb_rd),
      .wb_d     (wb_d),
      .de       (de_bus),
      .hazard   (hazard)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [1:0]  op_type;
      logic [5:0]  instr;
      logic [31:0] s;
      logic [31:0] t;
      logic [5:0]  rs;
      logic [5:0]  rt;
      logic [31:0] imm;
      logic        branch;
      logic        jump;
      logic        is_jr;
      logic [1:0]  rw;
      logic [4:0]  rd;
   } exp_t;

   exp_t        m_de;
   int          m_pend;
   logic [31:0] m_gpr [32];
   logic [31:0] m_fpr [32];
   int          n_chk;
   int          n_fail;
   logic        e_rdy;
   logic        last_rdy;
   logic        last_hz;

   logic [5:0] op_tab [23] = '{6'h00, 6'h00, 6'h00, 6'h11, 6'h11,
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h23,
      6'h2B, 6'h31, 6'h31, 6'h39, 6'h04, 6'h05, 6'h02, 6'h03,
      6'h3F, 6'h3C};
   logic [5:0] rfn_tab [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
      6'h2A, 6'h00, 6'h02, 6'h03, 6'h08};
   logic [5:0] ffn_tab [13] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04,
      6'h05, 6'h06, 6'h07, 6'h20, 6'h24, 6'h32, 6'h3C, 6'h3E};

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mrd(input logic [5:0] id);
      if (id == 6'h00) return 32'h0;
      if (id[5] && wb_rw == 2'd2 && wb_rd == id[4:0]) return wb_d;
      if (!id[5] && wb_rw == 2'd1 && wb_rd == id[4:0]) return wb_d;
      return id[5] ? m_fpr[id[4:0]] : m_gpr[id[4:0]];
   endfunction

   function automatic exp_t mdec(input logic [31:0] w,
                                 input logic [31:0] pc);
      exp_t        e;
      logic [31:0] sx, zx;
      logic        lnk;
      e     = '0;
      lnk   = 1'b0;
      sx    = {{16{w[15]}}, w[15:0]};
      zx    = {16'h0, w[15:0]};
      e.pc  = pc;
      e.instr = w[31:26];
      if (w[31:26] == 6'h00) begin
         e.op_type = 2'd1;
         e.instr   = w[5:0];
         e.rs      = {1'b0, w[25:21]};
         e.rt      = {1'b0, w[20:16]};
         e.imm     = sx;
         if (w[5:0] == 6'h08) e.is_jr = 1'b1;
         else begin e.rw = 2'd1; e.rd = w[15:11]; end
      end else if (w[31:26] == 6'h11) begin
         e.op_type = 2'd2;
         e.instr   = w[5:0];
         e.rd      = w[10:6];
         case (w[5:0])
            6'h32, 6'h3C, 6'h3E: begin
               e.rs = {1'b1, w[15:11]}; e.rt = {1'b1, w[20:16]};
               e.rw = 2'd1;
            end
            6'h24: begin e.rs = {1'b1, w[15:11]}; e.rw = 2'd1; end
            6'h20: begin e.rs = {1'b0, w[15:11]}; e.rw = 2'd2; end
            6'h04, 6'h05, 6'h06, 6'h07: begin
               e.rs = {1'b1, w[15:11]}; e.rw = 2'd2;
            end
            default: begin
               e.rs = {1'b1, w[15:11]}; e.rt = {1'b1, w[20:16]};
               e.rw = 2'd2;
            end
         endcase
      end else begin
         case (w[31:26])
            6'h08, 6'h0A, 6'h23: begin
               e.rs = {1'b0, w[25:21]}; e.imm = sx;
               e.rw = 2'd1; e.rd = w[20:16];
            end
            6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
               e.rs = {1'b0, w[25:21]}; e.imm = zx;
               e.rw = 2'd1; e.rd = w[20:16];
            end
            6'h31: begin
               e.rs = {1'b0, w[25:21]}; e.imm = sx;
               e.rw = 2'd2; e.rd = w[20:16];
            end
            6'h2B: begin
               e.rs = {1'b0, w[25:21]}; e.rt = {1'b0, w[20:16]};
               e.imm = sx;
            end
            6'h39: begin
               e.rs = {1'b0, w[25:21]}; e.rt = {1'b1, w[20:16]};
               e.imm = sx;
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
               e.rs = {1'b0, w[25:21]}; e.rt = {1'b0, w[20:16]};
               e.imm = sx; e.branch = 1'b1;
            end
            6'h02: begin e.imm = {6'h0, w[25:0]}; e.jump = 1'b1; end
            6'h03: begin
               e.imm = {6'h0, w[25:0]}; e.jump = 1'b1;
               e.rw = 2'd1; e.rd = 5'd31; lnk = 1'b1;
            end
            6'h3F: e.rs = {1'b0, w[25:21]};
            default: ;
         endcase
      end
      e.s = lnk ? pc + 32'd4 : mrd(e.rs);
      e.t = mrd(e.rt);
      return e;
   endfunction

   task automatic check_de(input bit all);
      check("de_valid", de_bus.de_valid, m_de.valid);
      if (all || m_de.valid) begin
         check("de_pc", de_bus.de_pc, m_de.pc);
         check("de_op_type", de_bus.de_op_type, m_de.op_type);
         check("de_instr", de_bus.de_instr, m_de.instr);
         check("de_s", de_bus.de_s, m_de.s);
         check("de_t", de_bus.de_t, m_de.t);
         check("de_rs", de_bus.de_rs, m_de.rs);
         check("de_rt", de_bus.de_rt, m_de.rt);
         check("de_imm", de_bus.de_imm, m_de.imm);
         check("de_branch", de_bus.de_branch, m_de.branch);
         check("de_jump", de_bus.de_jump, m_de.jump);
         check("de_is_jr", de_bus.de_is_jr, m_de.is_jr);
         check("de_rw", de_bus.de_rw, m_de.rw);
         check("de_rd", de_bus.de_rd, m_de.rd);
      end
   endtask

   task automatic step();
      exp_t       nx, d;
      logic       e_hz, ld, dep, in_rst;
      logic [5:0] dst;
      int         pend_n;
      in_rst = !rstn;
      nx     = m_de;
      pend_n = m_pend;
      ld  = m_de.valid && m_de.op_type == 2'd0 &&
            (m_de.instr == 6'h23 || m_de.instr == 6'h31);
      dst = {m_de.rw == 2'd2, m_de.rd};
      d   = mdec(fd_bus.fd_instr, fd_bus.fd_pc);
      dep = fd_bus.fd_valid && ld && dst != 6'h00 &&
            (d.rs == dst || d.rt == dst);
      if (in_rst) begin
         e_rdy = 0; e_hz = 0; nx = '0; pend_n = 0;
      end else if (flush) begin
         e_rdy = 1; e_hz = 0; nx.valid = 0; pend_n = 0;
      end else if (ex_stall) begin
         e_rdy = 0; e_hz = 0;
      end else if (m_pend > 0 || dep) begin
         e_rdy = 0; e_hz = 1; nx.valid = 0;
         pend_n = (m_pend > 0) ? m_pend - 1 : LB - 1;
      end else begin
         e_rdy = 1; e_hz = 0; nx = d; nx.valid = fd_bus.fd_valid;
      end
      @(negedge clk);
      last_rdy = fd_bus.fd_ready;
      last_hz  = hazard;
      check("fd_ready", last_rdy, e_rdy);
      check("hazard", last_hz, e_hz);
      @(posedge clk);
      #1;
      if (in_rst) begin
         for (int i = 0; i < 32; i++) begin
            m_gpr[i] = 0; m_fpr[i] = 0;
         end
      end else begin
         if (wb_rw == 2'd1 && wb_rd != 0) m_gpr[wb_rd] = wb_d;
         if (wb_rw == 2'd2) m_fpr[wb_rd] = wb_d;
      end
      m_de   = nx;
      m_pend = pend_n;
      check_de(in_rst);
   endtask

   task automatic issue(input logic [31:0] w, input logic [31:0] pc);
      fd_bus.fd_valid = 1'b1;
      fd_bus.fd_instr = w;
      fd_bus.fd_pc    = pc;
      step();
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [31:0] w;
      logic [5:0]  op;
      w  = $urandom;
      op = op_tab[$urandom_range(0, 22)];
      w[31:26] = op;
      w[25:21] = 5'($urandom_range(0, 7));
      w[20:16] = 5'($urandom_range(0, 7));
      w[15:11] = 5'($urandom_range(0, 7));
      if (op == 6'h00) w[5:0] = rfn_tab[$urandom_range(0, 9)];
      if (op == 6'h11) begin
         w[5:0]  = ffn_tab[$urandom_range(0, 12)];
         w[10:6] = 5'($urandom_range(0, 7));
      end
      return w;
   endfunction

   initial begin
      logic [31:0] pc;
      logic        need_new;
      n_chk  = 0;
      n_fail = 0;
      m_pend = 0;
      m_de   = '0;
      for (int i = 0; i < 32; i++) begin
         m_gpr[i] = 0; m_fpr[i] = 0;
      end
      rstn            = 1'b0;
      ex_stall        = 1'b1;
      flush           = 1'b1;
      wb_rw           = 2'd1;
      wb_rd           = 5'd3;
      wb_d            = $urandom;
      fd_bus.fd_valid = 1'b1;
      fd_bus.fd_instr = $urandom;
      fd_bus.fd_pc    = $urandom;
      step();
      step();

      rstn     = 1'b1;
      ex_stall = 1'b0;
      flush    = 1'b0;
      wb_rw    = 2'd0;
      issue(32'h00430820, 32'h10);
      check("rst_gpr_s", de_bus.de_s, 32'h0);
      check("rst_gpr_t", de_bus.de_t, 32'h0);
      issue(32'h46831000, 32'h14);
      check("rst_fpr_s", de_bus.de_s, 32'h0);

      fd_bus.fd_valid = 1'b0;
      wb_rw = 2'd1; wb_rd = 5'd2; wb_d = 32'd10;
      step();
      wb_rw = 2'd0;
      issue(32'h2043FFFB, 32'h40);
      check("addi_type", de_bus.de_op_type, 32'h0);
      check("addi_instr", de_bus.de_instr, 32'h08);
      check("addi_s", de_bus.de_s, 32'd10);
      check("addi_imm", de_bus.de_imm, 32'hFFFFFFFB);
      check("addi_rw", de_bus.de_rw, 32'h1);
      check("addi_rd", de_bus.de_rd, 32'h3);
      check("addi_rs", de_bus.de_rs, 32'h02);

      wb_rw = 2'd1; wb_rd = 5'd5; wb_d = 32'h1234;
      issue(32'h00A03020, 32'h44);
      check("wt_s", de_bus.de_s, 32'h1234);
      check("wt_t", de_bus.de_t, 32'h0);
      wb_rd = 5'd0; wb_d = 32'hDEAD;
      issue(32'h00003020, 32'h48);
      check("gpr0_wt", de_bus.de_s, 32'h0);
      wb_rw = 2'd0;
      issue(32'h00003020, 32'h4C);
      check("gpr0_rd", de_bus.de_s, 32'h0);

      issue(32'h8C240000, 32'h50);
      issue(32'h00843820, 32'h54);
      check("lu_hazard", last_hz, 1'b1);
      check("lu_ready", last_rdy, 1'b0);
      check("lu_bubble", de_bus.de_valid, 1'b0);
      step();
      check("lu_issue", de_bus.de_valid, 1'b1);
      check("lu_pc", de_bus.de_pc, 32'h54);
      issue(32'h8C240000, 32'h58);
      issue(32'h00A53820, 32'h5C);
      check("nolu_hazard", last_hz, 1'b0);
      check("nolu_issue", de_bus.de_pc, 32'h5C);

      issue(32'h0C000040, 32'h100);
      check("jal_jump", de_bus.de_jump, 1'b1);
      check("jal_imm", de_bus.de_imm, 32'h40);
      check("jal_s", de_bus.de_s, 32'h104);
      check("jal_rw", de_bus.de_rw, 32'h1);
      check("jal_rd", de_bus.de_rd, 32'd31);
      issue(32'h30018000, 32'h104);
      check("andi_imm", de_bus.de_imm, 32'h00008000);

      issue(32'h34020055, 32'h200);
      ex_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         issue(rnd_instr(), 32'h204 + 32'(4 * i));
         check("stall_pc", de_bus.de_pc, 32'h200);
         check("stall_rdy", last_rdy, 1'b0);
      end
      flush = 1'b1;
      issue(32'h00A53820, 32'h300);
      check("flush_rdy", last_rdy, 1'b1);
      check("flush_kill", de_bus.de_valid, 1'b0);
      flush = 1'b0;
      ex_stall = 1'b0;
      fd_bus.fd_valid = 1'b0;
      step();
      check("flush_drop", de_bus.de_valid, 1'b0);

      pc = 32'h1000;
      need_new = 1'b1;
      for (int i = 0; i < 600; i++) begin
         ex_stall = ($urandom_range(0, 9) == 0);
         flush    = ($urandom_range(0, 19) == 0);
         wb_rw    = 2'($urandom_range(0, 3));
         wb_rd    = 5'($urandom_range(0, 7));
         wb_d     = $urandom;
         if (need_new) begin
            fd_bus.fd_valid = ($urandom_range(0, 4) != 0);
            fd_bus.fd_instr = rnd_instr();
            fd_bus.fd_pc    = pc;
            pc = pc + 32'd4;
         end
         step();
         need_new = e_rdy;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
